// File: rtl/rs_register_bank.sv
// Bank of WIDTH clocked RS storage bits with a shared enable, runtime-selectable
// resolution of the r=s=1 case, sticky per-bit violation flags and a saturating
// violation counter.
module rs_register_bank #(
  parameter int unsigned      WIDTH  = 8,
  parameter int unsigned      CNT_W  = 4,
  parameter logic [WIDTH-1:0] INIT_Q = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  logic [1:0]       mode,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic             err_any
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic [WIDTH-1:0] err_flag_q, err_flag_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0] collide;
  logic [WIDTH-1:0] resolved;

  assign collide = r & s;

  // Value a colliding bit takes, chosen by the current mode.
  always_comb begin
    resolved = q_q;
    case (mode)
      2'b00:   resolved = q_q;
      2'b01:   resolved = '1;
      2'b10:   resolved = '0;
      default: resolved = ~q_q;
    endcase
  end

  // Next-state for storage, change pulses and error tracking.
  always_comb begin
    q_d         = q_q;
    changed_d   = '0;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (enable) begin
      // Hold where r=s=0, set-only, reset-only, and mode-resolved collisions.
      q_d       = (q_q & ~r & ~s) | (s & ~r) | (collide & resolved);
      changed_d = q_d ^ q_q;
    end
    // Clear wins over a violation on the same edge.
    if (clr_err) begin
      err_flag_d  = '0;
      err_count_d = '0;
    end else if (enable) begin
      err_flag_d = err_flag_q | collide;
      if (|collide && err_count_q != CntMax) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q         <= INIT_Q;
      changed_q   <= '0;
      err_flag_q  <= '0;
      err_count_q <= '0;
    end else begin
      q_q         <= q_d;
      changed_q   <= changed_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign q         = q_q;
  assign q_n       = ~q_q;
  assign changed   = changed_q;
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;
  assign err_any   = |err_flag_q;

endmodule

// File: tb/tb_rs_register_bank.sv
// Self-checking bench for rs_register_bank: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the bit rules.
module tb_rs_register_bank;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [7:0]  INIT_Q = 8'hA5;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] r, s;
  logic [1:0] mode;
  logic       clr_err;
  logic [7:0] q, q_n, changed, err_flag;
  logic [3:0] err_count;
  logic       err_any;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] m_q, m_changed, m_flag;
  int         m_cnt;

  rs_register_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W), .INIT_Q(INIT_Q)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .r        (r),
    .s        (s),
    .mode     (mode),
    .clr_err  (clr_err),
    .q        (q),
    .q_n      (q_n),
    .changed  (changed),
    .err_flag (err_flag),
    .err_count(err_count),
    .err_any  (err_any)
  );

  always #5 clk = ~clk;

  // Advance the model by one edge using the current inputs, then let the DUT clock.
  task automatic tick();
    logic [7:0] nq;
    bit         any_collide;
    if (!rst_n) begin
      m_q = INIT_Q; m_changed = '0; m_flag = '0; m_cnt = 0;
    end else begin
      nq = m_q;
      any_collide = 1'b0;
      if (enable) begin
        for (int i = 0; i < 8; i++) begin
          if (r[i] && s[i]) begin
            any_collide = 1'b1;
            case (mode)
              2'd0: nq[i] = m_q[i];
              2'd1: nq[i] = 1'b1;
              2'd2: nq[i] = 1'b0;
              default: nq[i] = !m_q[i];
            endcase
          end else if (s[i]) begin
            nq[i] = 1'b1;
          end else if (r[i]) begin
            nq[i] = 1'b0;
          end
        end
      end
      m_changed = '0;
      for (int i = 0; i < 8; i++) m_changed[i] = (nq[i] != m_q[i]);
      if (clr_err) begin
        m_flag = '0; m_cnt = 0;
      end else if (enable) begin
        for (int i = 0; i < 8; i++) if (r[i] && s[i]) m_flag[i] = 1'b1;
        if (any_collide && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
      m_q = nq;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [7:0] rv, input logic [7:0] sv,
                       input logic [1:0] md, input logic clr);
    enable = en; r = rv; s = sv; mode = md; clr_err = clr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 8'h00, 8'hFF, 2'd0, 1'b0);
    tick();
    tick();
    n_checks++;
    if (q !== 8'hA5) begin n_fail++; $display("FAIL reset_q: got %h want a5", q); end
    n_checks++;
    if (q_n !== 8'h5A) begin n_fail++; $display("FAIL reset_q_n: got %h want 5a", q_n); end
    n_checks++;
    if (err_count !== 4'd0 || err_flag !== 8'h00 || err_any !== 1'b0 || changed !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_err: cnt=%0d flag=%h any=%b chg=%h want 0/00/0/00",
               err_count, err_flag, err_any, changed);
    end
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'hFF, 2'd0, 1'b0);
    tick();
    n_checks++;
    if (q !== 8'hA5 || changed !== 8'h00) begin
      n_fail++; $display("FAIL disabled_hold: q=%h chg=%h want a5/00", q, changed);
    end
  endtask

  task automatic test_set_reset_hold();
    drive(1'b1, 8'h00, 8'h0F, 2'd0, 1'b0);
    tick();
    n_checks++;
    if (q !== 8'hAF || changed !== 8'h0A) begin
      n_fail++; $display("FAIL set: q=%h chg=%h want af/0a", q, changed);
    end
    drive(1'b1, 8'hF0, 8'h00, 2'd0, 1'b0);
    tick();
    n_checks++;
    if (q !== 8'h0F || changed !== 8'hA0) begin
      n_fail++; $display("FAIL reset: q=%h chg=%h want 0f/a0", q, changed);
    end
    drive(1'b1, 8'h00, 8'h00, 2'd0, 1'b0);
    tick();
    n_checks++;
    if (q !== 8'h0F || changed !== 8'h00) begin
      n_fail++; $display("FAIL hold: q=%h chg=%h want 0f/00", q, changed);
    end
    // Writing a 1 over a stored 1 is not a change.
    drive(1'b1, 8'h00, 8'h0F, 2'd0, 1'b0);
    tick();
    n_checks++;
    if (q !== 8'h0F || changed !== 8'h00) begin
      n_fail++; $display("FAIL same_write: q=%h chg=%h want 0f/00", q, changed);
    end
  endtask

  task automatic test_forbidden_modes();
    drive(1'b1, 8'h11, 8'h11, 2'd0, 1'b0);
    tick();
    n_checks++;
    if (q !== 8'h0F) begin n_fail++; $display("FAIL mode_hold: got %h want 0f", q); end
    drive(1'b1, 8'h11, 8'h11, 2'd1, 1'b0);
    tick();
    n_checks++;
    if (q !== 8'h1F) begin n_fail++; $display("FAIL mode_set: got %h want 1f", q); end
    drive(1'b1, 8'h10, 8'h00, 2'd1, 1'b0);
    tick();
    drive(1'b1, 8'h11, 8'h11, 2'd2, 1'b0);
    tick();
    n_checks++;
    if (q !== 8'h0E) begin n_fail++; $display("FAIL mode_reset: got %h want 0e", q); end
    drive(1'b1, 8'h00, 8'h01, 2'd2, 1'b0);
    tick();
    drive(1'b1, 8'h11, 8'h11, 2'd3, 1'b0);
    tick();
    n_checks++;
    if (q !== 8'h1E || changed !== 8'h11) begin
      n_fail++; $display("FAIL toggle1: q=%h chg=%h want 1e/11", q, changed);
    end
    tick();
    n_checks++;
    if (q !== 8'h0F) begin n_fail++; $display("FAIL toggle2: got %h want 0f", q); end
    n_checks++;
    if (err_flag !== 8'h11 || err_count !== 4'(m_cnt)) begin
      n_fail++; $display("FAIL mode_errs: flag=%h cnt=%0d want 11/%0d", err_flag, err_count, m_cnt);
    end
  endtask

  task automatic test_error_saturation();
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    tick();
    n_checks++;
    if (err_flag !== 8'h00 || err_count !== 4'd0) begin
      n_fail++; $display("FAIL clear: flag=%h cnt=%0d want 00/0", err_flag, err_count);
    end
    drive(1'b1, 8'h01, 8'h01, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (err_flag !== 8'h01 || err_any !== 1'b1) begin
      n_fail++; $display("FAIL sat_flag: flag=%h any=%b want 01/1", err_flag, err_any);
    end
    n_checks++;
    if (err_count !== 4'd15) begin n_fail++; $display("FAIL sat_cnt: got %0d want 15", err_count); end
  endtask

  task automatic test_enable_gating();
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    tick();
    drive(1'b0, 8'hFF, 8'hFF, 2'd3, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (err_flag !== 8'h00 || err_count !== 4'd0 || err_any !== 1'b0) begin
      n_fail++; $display("FAIL gate_err: flag=%h cnt=%0d want 00/0", err_flag, err_count);
    end
    n_checks++;
    if (q !== m_q || changed !== 8'h00) begin
      n_fail++; $display("FAIL gate_q: q=%h chg=%h want %h/00", q, changed, m_q);
    end
  endtask

  task automatic test_clear_vs_violation();
    drive(1'b1, 8'h01, 8'h01, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (err_count !== 4'd3) begin n_fail++; $display("FAIL cnt3: got %0d want 3", err_count); end
    drive(1'b1, 8'h80, 8'h80, 2'd1, 1'b1);
    tick();
    n_checks++;
    if (err_count !== 4'd0 || err_flag !== 8'h00) begin
      n_fail++; $display("FAIL clr_wins: cnt=%0d flag=%h want 0/00", err_count, err_flag);
    end
    n_checks++;
    if (q[7] !== 1'b1 || q !== m_q) begin
      n_fail++; $display("FAIL clr_q: got %h want %h", q, m_q);
    end
  endtask

  task automatic test_reset_midrun();
    drive(1'b1, 8'hFF, 8'hFF, 2'd3, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (q !== 8'hA5 || changed !== 8'h00 || err_count !== 4'd0 || err_flag !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: q=%h chg=%h cnt=%0d flag=%h want a5/00/0/00",
               q, changed, err_count, err_flag);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (q !== 8'h5A || changed !== 8'hFF || err_count !== 4'd1) begin
      n_fail++;
      $display("FAIL post_reset: q=%h chg=%h cnt=%0d want 5a/ff/1", q, changed, err_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 2'($urandom),
            ($urandom_range(0, 19) == 0));
      tick();
      n_checks++;
      if (q !== m_q || q_n !== ~m_q || changed !== m_changed) begin
        n_fail++;
        $display("FAIL rand_q[%0d]: q=%h q_n=%h chg=%h want %h/%h/%h",
                 n, q, q_n, changed, m_q, ~m_q, m_changed);
      end
      n_checks++;
      if (err_flag !== m_flag || err_count !== 4'(m_cnt) || err_any !== (m_flag != 8'h00)) begin
        n_fail++;
        $display("FAIL rand_err[%0d]: flag=%h cnt=%0d any=%b want %h/%0d/%b",
                 n, err_flag, err_count, err_any, m_flag, m_cnt, (m_flag != 8'h00));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
    m_q = INIT_Q; m_changed = '0; m_flag = '0; m_cnt = 0;
    test_reset();
    test_set_reset_hold();
    test_forbidden_modes();
    test_error_saturation();
    test_enable_gating();
    test_clear_vs_violation();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
